writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus result-select/load-extend logic for the RV32I core.

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/load_extend.sv | 49 ++++
 rtl/writeback_stage.sv | 96 +++++++++
 tb/tb_writeback_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the writeback stage: result-source select
// and load funct3 codes.
package rv32i_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: picks the byte/half/word addressed by
// off out of an aligned memory word, extends it and flags misalignment.
module load_extend
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = word[8*gi +: 8];
    end

    assign byte_sel = byte_lane[off];
    assign half_sel = off[1] ? {byte_lane[3], byte_lane[2]} : {byte_lane[1], byte_lane[0]};

    // Misaligned accesses return 0 so the caller never sees partial data.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                if (off[0]) misalign = 1'b1;
                else        data = {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
                if (off[0]) misalign = 1'b1;
                else        data = {{(XLEN-16){1'b0}}, half_sel};
            end
            F3_LW: begin
                if (off != 2'b00) misalign = 1'b1;
                else              data = word;
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, result select and retired-instruction counter
// feeding the register-file write port.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_M,
    input  logic             RegWrite_M,
    input  logic [4:0]       rd_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic [2:0]       funct3_M,
    input  logic [XLEN-1:0]  ALUResult_M,
    input  logic [XLEN-1:0]  ReadData_M,
    input  logic [XLEN-1:0]  PCPlus4_M,
    output logic             RegWrite_W,
    output logic [4:0]       rd_W,
    output logic [XLEN-1:0]  WD3_W,
    output logic             misalign_W,
    output logic [CNT_W-1:0] retired
);

    logic            valid_q;
    logic            RegWrite_q;
    logic [4:0]      rd_q;
    logic [1:0]      ResultSrc_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] ALUResult_q;
    logic [XLEN-1:0] ReadData_q;
    logic [XLEN-1:0] PCPlus4_q;

    logic [XLEN-1:0] load_data;
    logic            load_misalign;

    // Flush only kills valid; the payload is left as-is since a bubble never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            RegWrite_q  <= 1'b0;
            rd_q        <= '0;
            ResultSrc_q <= '0;
            funct3_q    <= '0;
            ALUResult_q <= '0;
            ReadData_q  <= '0;
            PCPlus4_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= valid_M;
            RegWrite_q  <= RegWrite_M;
            rd_q        <= rd_M;
            ResultSrc_q <= ResultSrc_M;
            funct3_q    <= funct3_M;
            ALUResult_q <= ALUResult_M;
            ReadData_q  <= ReadData_M;
            PCPlus4_q   <= PCPlus4_M;
        end
    end

    // Counts the instruction leaving WB, so only edges where it actually advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (valid_q && !stall && !flush) begin
            retired <= retired + CNT_W'(1);
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3   (funct3_q),
        .off      (ALUResult_q[1:0]),
        .word     (ReadData_q),
        .data     (load_data),
        .misalign (load_misalign)
    );

    always_comb begin
        WD3_W = '0;
        case (ResultSrc_q)
            RES_ALU: WD3_W = ALUResult_q;
            RES_MEM: WD3_W = load_data;
            RES_PC4: WD3_W = PCPlus4_q;
            default: WD3_W = '0;
        endcase
    end

    assign misalign_W = valid_q && (ResultSrc_q == RES_MEM) && load_misalign;
    assign RegWrite_W = valid_q && RegWrite_q && (rd_q != 5'd0) && !misalign_W;
    assign rd_W       = rd_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected WB outputs are queued as each
// MEM bundle is driven and compared after the capturing edge.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_M, RegWrite_M;
    logic [4:0]  rd_M;
    logic [1:0]  ResultSrc_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALUResult_M, ReadData_M, PCPlus4_M;

    logic        RegWrite_W, misalign_W, RegWrite_W4, misalign_W4;
    logic [4:0]  rd_W, rd_W4;
    logic [31:0] WD3_W, WD3_W4, retired;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_M(valid_M),
        .RegWrite_M(RegWrite_M), .rd_M(rd_M), .ResultSrc_M(ResultSrc_M),
        .funct3_M(funct3_M), .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M),
        .PCPlus4_M(PCPlus4_M), .RegWrite_W(RegWrite_W), .rd_W(rd_W),
        .WD3_W(WD3_W), .misalign_W(misalign_W), .retired(retired)
    );

    writeback_stage #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_M(valid_M),
        .RegWrite_M(RegWrite_M), .rd_M(rd_M), .ResultSrc_M(ResultSrc_M),
        .funct3_M(funct3_M), .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M),
        .PCPlus4_M(PCPlus4_M), .RegWrite_W(RegWrite_W4), .rd_W(rd_W4),
        .WD3_W(WD3_W4), .misalign_W(misalign_W4), .retired(retired4)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        mis;
        logic        full;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic        m_valid;
    logic [31:0] m_ret;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic v, input logic rw, input logic [4:0] rd,
                                   input logic [1:0] src, input logic [2:0] f3,
                                   input logic [31:0] alu, input logic [31:0] rdat,
                                   input logic [31:0] pc4);
        exp_t        e;
        logic [1:0]  off;
        logic [31:0] sh8, sh16, ld;
        logic        lmis;
        off  = alu[1:0];
        sh8  = rdat >> (8 * off);
        sh16 = rdat >> (16 * off[1]);
        ld   = 32'h0;
        lmis = 1'b0;
        case (f3)
            3'b000: ld = {{24{sh8[7]}}, sh8[7:0]};
            3'b100: ld = {24'h0, sh8[7:0]};
            3'b001: if (off[0]) lmis = 1'b1; else ld = {{16{sh16[15]}}, sh16[15:0]};
            3'b101: if (off[0]) lmis = 1'b1; else ld = {16'h0, sh16[15:0]};
            3'b010: if (off != 2'b00) lmis = 1'b1; else ld = rdat;
            default: ld = 32'h0;
        endcase
        case (src)
            2'b00:   e.wd = alu;
            2'b01:   e.wd = lmis ? 32'h0 : ld;
            2'b10:   e.wd = pc4;
            default: e.wd = 32'h0;
        endcase
        e.mis  = v && (src == 2'b01) && lmis;
        e.rw   = v && rw && (rd != 5'd0) && !e.mis;
        e.rd   = rd;
        e.full = 1'b1;
        return e;
    endfunction

    task automatic step(input string name, input logic r, input logic s, input logic f,
                        input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [31:0] pc4);
        exp_t e;
        rst = r; stall = s; flush = f; valid_M = v; RegWrite_M = rw; rd_M = rd;
        ResultSrc_M = src; funct3_M = f3; ALUResult_M = alu; ReadData_M = rdat;
        PCPlus4_M = pc4;
        if (r) begin
            e = '{rw: 1'b0, rd: 5'd0, wd: 32'h0, mis: 1'b0, full: 1'b1};
            m_ret = 32'h0;
            m_valid = 1'b0;
        end else if (f) begin
            e = last_exp;
            e.rw = 1'b0; e.mis = 1'b0; e.full = 1'b0;
            m_valid = 1'b0;
        end else if (s) begin
            e = last_exp;
        end else begin
            if (m_valid) m_ret = m_ret + 32'h1;
            m_valid = v;
            e = model(v, rw, rd, src, f3, alu, rdat, pc4);
        end
        last_exp = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d %s: rw=%0b rd=%0d wd=%h mis=%0b ret=%0d ret4=%0d", n_txn, name,
                 RegWrite_W, rd_W, WD3_W, misalign_W, retired, retired4);
        check({name, ".RegWrite_W"}, {31'h0, RegWrite_W}, {31'h0, e.rw});
        check({name, ".misalign_W"}, {31'h0, misalign_W}, {31'h0, e.mis});
        if (e.full) begin
            check({name, ".rd_W"}, {27'h0, rd_W}, {27'h0, e.rd});
            check({name, ".WD3_W"}, WD3_W, e.wd);
        end
        check({name, ".retired"}, retired, m_ret);
        check({name, ".retired4"}, {28'h0, retired4}, {28'h0, m_ret[3:0]});
    endtask

    localparam logic [31:0] RDAT = 32'h80FF7F01;

    initial begin
        logic [2:0] f3_tab [8];
        m_valid = 1'b0;
        m_ret = 32'h0;
        last_exp = '0;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010; f3_tab[3] = 3'b100;
        f3_tab[4] = 3'b101; f3_tab[5] = 3'b011; f3_tab[6] = 3'b110; f3_tab[7] = 3'b010;

        step("reset",   1, 0, 0, 0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        step("alu",     0, 0, 0, 1, 1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h8);
        step("lb3",     0, 0, 0, 1, 1, 5'd6, 2'b01, 3'b000, 32'h103, RDAT, 32'hC);
        step("lbu3",    0, 0, 0, 1, 1, 5'd7, 2'b01, 3'b100, 32'h103, RDAT, 32'h10);
        step("lh2",     0, 0, 0, 1, 1, 5'd8, 2'b01, 3'b001, 32'h102, RDAT, 32'h14);
        step("lhu0",    0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b101, 32'h100, RDAT, 32'h18);
        step("lw_mis",  0, 0, 0, 1, 1, 5'd10, 2'b01, 3'b010, 32'h102, RDAT, 32'h1C);
        step("lh_mis",  0, 0, 0, 1, 1, 5'd11, 2'b01, 3'b101, 32'h101, RDAT, 32'h20);
        step("lw",      0, 0, 0, 1, 1, 5'd12, 2'b01, 3'b010, 32'h104, RDAT, 32'h24);
        step("x0",      0, 0, 0, 1, 1, 5'd0, 2'b00, 3'b000, 32'hBEEF, 32'h0, 32'h28);
        step("pc4",     0, 0, 0, 1, 1, 5'd1, 2'b10, 3'b000, 32'h55, 32'h0, 32'h2C);
        step("rsvd",    0, 0, 0, 1, 1, 5'd2, 2'b11, 3'b000, 32'h66, 32'h0, 32'h30);
        step("bad_f3",  0, 0, 0, 1, 1, 5'd3, 2'b01, 3'b111, 32'h100, RDAT, 32'h34);
        step("bubble",  0, 0, 0, 0, 1, 5'd4, 2'b00, 3'b000, 32'h77, 32'h0, 32'h38);
        step("alu2",    0, 0, 0, 1, 1, 5'd13, 2'b00, 3'b000, 32'hCAFE, 32'h0, 32'h3C);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, 1, 1, 5'd14, 2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h40);
        step("resume",  0, 0, 0, 1, 1, 5'd15, 2'b00, 3'b000, 32'h1111, 32'h0, 32'h44);
        step("stl_fl",  0, 1, 1, 1, 1, 5'd16, 2'b00, 3'b000, 32'h2222, 32'h0, 32'h48);
        step("alu3",    0, 0, 0, 1, 1, 5'd17, 2'b00, 3'b000, 32'h3333, 32'h0, 32'h4C);
        step("rst_mid", 1, 0, 0, 1, 1, 5'd18, 2'b00, 3'b000, 32'h4444, 32'h0, 32'h50);
        step("rst_mid", 1, 0, 0, 1, 1, 5'd19, 2'b00, 3'b000, 32'h5555, 32'h0, 32'h54);
        for (int i = 0; i < 17; i++)
            step("wrap", 0, 0, 0, 1, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i * 3), 32'h0, 32'h0);
        check("wrap.retired4_zero", {28'h0, retired4}, 32'h0);
        for (int i = 0; i < 80; i++) begin
            logic r, s, f;
            r = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 6) == 0);
            f = ($urandom_range(0, 7) == 0);
            step("rand", r, s, f, 1'($urandom), 1'($urandom), 5'($urandom),
                 2'($urandom), f3_tab[$urandom_range(0, 7)], $urandom, $urandom, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
